// File: rtl/pu_or1k_tap_scheduler.sv
// Result-stream sequencer for the TAP writer: round-robin arbitration over the
// self-checking requesters, one plan header, then one numbered record per testcase.
module pu_or1k_tap_scheduler #(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_TESTS = 16,
  parameter  int DESC_W    = 8,
  parameter  int TIMEOUT   = 1024,
  localparam int CNT_W     = $clog2(NUM_TESTS + 1)
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      start_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_ok_i,
  input  logic [NUM_REQ*DESC_W-1:0] req_desc_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tc_valid_o,
  input  logic                      tc_ready_i,
  output logic                      tc_hdr_o,
  output logic [CNT_W-1:0]          tc_num_o,
  output logic                      tc_ok_o,
  output logic [DESC_W-1:0]         tc_desc_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      timeout_o,
  output logic [CNT_W-1:0]          pass_cnt_o,
  output logic [CNT_W-1:0]          fail_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ARB,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [TMR_W-1:0]   idle_tmr;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_next;
  logic [CNT_W-1:0]   emitted_inc;

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned       cand;
      logic [PTR_W-1:0]  cand_idx;
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!grant_vld && req_valid_i[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign rr_next     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign emitted_inc = pass_cnt_o + fail_cnt_o + CNT_W'(1);

  // The accept pulse is the only unregistered output; requesters see it in the grant cycle.
  always_comb begin
    req_ready_o = '0;
    if (state == S_ARB && grant_vld) req_ready_o = NUM_REQ'(1) << grant_idx;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // right-hand side reads the pre-edge value.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      idle_tmr   <= '0;
      tc_valid_o <= 1'b0;
      tc_hdr_o   <= 1'b0;
      tc_num_o   <= '0;
      tc_ok_o    <= 1'b0;
      tc_desc_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state      <= S_HDR;
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            busy_o     <= 1'b1;
            tc_valid_o <= 1'b1;
            tc_hdr_o   <= 1'b1;
            tc_num_o   <= CNT_W'(NUM_TESTS);
            tc_ok_o    <= 1'b0;
            tc_desc_o  <= '0;
          end
        end

        S_HDR: begin
          if (tc_ready_i) begin
            state      <= S_ARB;
            tc_valid_o <= 1'b0;
            tc_hdr_o   <= 1'b0;
            idle_tmr   <= '0;
          end
        end

        S_ARB: begin
          if (grant_vld) begin
            state      <= S_EMIT;
            rr_ptr     <= rr_next;
            idle_tmr   <= '0;
            tc_valid_o <= 1'b1;
            tc_num_o   <= emitted_inc;
            tc_ok_o    <= req_ok_i[grant_idx];
            tc_desc_o  <= req_desc_i[grant_idx*DESC_W +: DESC_W];
          end else if (idle_tmr == TMR_W'(TIMEOUT - 1)) begin
            state     <= S_DONE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end else begin
            idle_tmr <= idle_tmr + TMR_W'(1);
          end
        end

        S_EMIT: begin
          if (tc_ready_i) begin
            tc_valid_o <= 1'b0;
            idle_tmr   <= '0;
            if (tc_ok_o) pass_cnt_o <= pass_cnt_o + CNT_W'(1);
            else         fail_cnt_o <= fail_cnt_o + CNT_W'(1);
            if (emitted_inc == CNT_W'(NUM_TESTS)) begin
              state  <= S_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state <= S_ARB;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_or1k_tap_scheduler.sv
// Self-checking bench for pu_or1k_tap_scheduler: directed and randomized sessions
// compared cycle by cycle against a transaction-level model of the result stream.
module tb_pu_or1k_tap_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int NUM_TESTS = 8;
  localparam int DESC_W    = 8;
  localparam int TIMEOUT   = 8;
  localparam int CNT_W     = $clog2(NUM_TESTS + 1);
  localparam int ALL_W     = NUM_REQ + DESC_W + 3*CNT_W + 6;

  logic                      PCLK        = 1'b0;
  logic                      PRESETn     = 1'b0;
  logic                      start_i     = 1'b0;
  logic                      tc_ready_i  = 1'b0;
  logic [NUM_REQ-1:0]        req_valid_i = '0;
  logic [NUM_REQ-1:0]        req_ok_i    = '0;
  logic [NUM_REQ*DESC_W-1:0] req_desc_i  = '0;

  logic [NUM_REQ-1:0] req_ready_o;
  logic               tc_valid_o, tc_hdr_o, tc_ok_o, busy_o, done_o, timeout_o;
  logic [CNT_W-1:0]   tc_num_o, pass_cnt_o, fail_cnt_o;
  logic [DESC_W-1:0]  tc_desc_o;

  wire [ALL_W-1:0] all_outs = {req_ready_o, tc_valid_o, tc_hdr_o, tc_num_o, tc_ok_o,
                               tc_desc_o, busy_o, done_o, timeout_o, pass_cnt_o, fail_cnt_o};

  int n_total  = 0;
  int n_passed = 0;
  int m_ptr    = 0;   // model round-robin pointer, survives sessions, cleared by reset
  int grants[$];

  pu_or1k_tap_scheduler #(
    .NUM_REQ(NUM_REQ), .NUM_TESTS(NUM_TESTS), .DESC_W(DESC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start_i(start_i),
    .req_valid_i(req_valid_i), .req_ok_i(req_ok_i), .req_desc_i(req_desc_i),
    .req_ready_o(req_ready_o), .tc_valid_o(tc_valid_o), .tc_ready_i(tc_ready_i),
    .tc_hdr_o(tc_hdr_o), .tc_num_o(tc_num_o), .tc_ok_o(tc_ok_o), .tc_desc_o(tc_desc_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One full session from a start pulse to DONE. mode 0: random traffic, 1: all requesters
  // valid, 2: as 1 with a 5-cycle stall on the first record, 3: no requests at all.
  task automatic run_session(input int mode, output int s_pass, output int s_fail,
                             output bit s_tmo);
    int  npass = 0, nfail = 0, idle = 0, stall = 0, exp_g, r_num = 0;
    bit  hdr_pend = 1'b1, rec_pend = 1'b0, fin = 1'b0, tmo = 1'b0, r_ok = 1'b0;
    logic [DESC_W-1:0]            r_desc = '0;
    logic [NUM_REQ-1:0]           exp_ready;
    logic [CNT_W+DESC_W:0]        exp_rec;
    logic [2*CNT_W+2:0]           exp_stat;
    grants.delete();

    start_i     = 1'b1;
    req_valid_i = (mode == 3) ? '0 : '1;
    tc_ready_i  = 1'b1;
    #1;
    n_total++;
    if (req_ready_o !== '0) $display("FAIL start_holdoff req_ready_o=%b expected 0", req_ready_o);
    else n_passed++;
    step();
    start_i = 1'b0;

    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      case (mode)
        0: begin
          req_valid_i = NUM_REQ'($urandom);
          req_ok_i    = NUM_REQ'($urandom);
          req_desc_i  = (NUM_REQ*DESC_W)'($urandom);
          tc_ready_i  = ($urandom_range(0, 3) != 0);
          start_i     = 1'($urandom_range(0, 1));
        end
        1, 2: begin
          req_valid_i = '1;
          req_ok_i    = NUM_REQ'(5);
          for (int k = 0; k < NUM_REQ; k++) req_desc_i[k*DESC_W +: DESC_W] = DESC_W'(k*16 + cyc);
          tc_ready_i = 1'b1;
          if (mode == 2 && rec_pend && stall < 5) begin
            tc_ready_i = 1'b0;
            stall++;
          end
        end
        default: begin
          req_valid_i = '0;
          tc_ready_i  = 1'b1;
        end
      endcase
      #1;

      exp_g = -1;
      if (!hdr_pend && !rec_pend)
        for (int k = 0; k < NUM_REQ; k++)
          if (exp_g < 0 && req_valid_i[(m_ptr + k) % NUM_REQ]) exp_g = (m_ptr + k) % NUM_REQ;
      exp_ready = '0;
      if (exp_g >= 0) exp_ready[exp_g] = 1'b1;

      n_total++;
      if (req_ready_o !== exp_ready)
        $display("FAIL req_ready cyc=%0d got=%b expected=%b", cyc, req_ready_o, exp_ready);
      else n_passed++;

      n_total++;
      if ({tc_valid_o, tc_hdr_o} !== {hdr_pend | rec_pend, hdr_pend})
        $display("FAIL tc_valid_hdr cyc=%0d got=%b%b expected=%b%b", cyc, tc_valid_o, tc_hdr_o,
                 hdr_pend | rec_pend, hdr_pend);
      else n_passed++;

      if (hdr_pend || rec_pend) begin
        exp_rec = hdr_pend ? {CNT_W'(NUM_TESTS), 1'b0, DESC_W'(0)}
                           : {CNT_W'(r_num), r_ok, r_desc};
        n_total++;
        if ({tc_num_o, tc_ok_o, tc_desc_o} !== exp_rec)
          $display("FAIL record_fields cyc=%0d got num=%0d ok=%b desc=%0h expected %h", cyc,
                   tc_num_o, tc_ok_o, tc_desc_o, exp_rec);
        else n_passed++;
      end

      exp_stat = {1'b1, 1'b0, 1'b0, CNT_W'(npass), CNT_W'(nfail)};
      n_total++;
      if ({busy_o, done_o, timeout_o, pass_cnt_o, fail_cnt_o} !== exp_stat)
        $display("FAIL status cyc=%0d got busy=%b done=%b tmo=%b pass=%0d fail=%0d expected %h",
                 cyc, busy_o, done_o, timeout_o, pass_cnt_o, fail_cnt_o, exp_stat);
      else n_passed++;

      if (hdr_pend) begin
        if (tc_ready_i) hdr_pend = 1'b0;
        idle = 0;
      end else if (rec_pend) begin
        if (tc_ready_i) begin
          rec_pend = 1'b0;
          if (r_ok) npass++;
          else      nfail++;
          if (npass + nfail == NUM_TESTS) fin = 1'b1;
          idle = 0;
        end
      end else if (exp_g >= 0) begin
        grants.push_back(exp_g);
        rec_pend = 1'b1;
        r_num    = npass + nfail + 1;
        r_ok     = req_ok_i[exp_g];
        r_desc   = req_desc_i[exp_g*DESC_W +: DESC_W];
        m_ptr    = (exp_g + 1) % NUM_REQ;
        idle     = 0;
      end else if (idle == TIMEOUT - 1) begin
        fin = 1'b1;
        tmo = 1'b1;
      end else begin
        idle++;
      end
      step();
    end

    if (!fin) begin
      n_total++;
      $display("FAIL session_bound mode=%0d session did not end within budget", mode);
    end

    start_i     = 1'b0;
    req_valid_i = '1;
    #1;
    n_total++;
    if (req_ready_o !== '0) $display("FAIL done_holdoff req_ready_o=%b expected 0", req_ready_o);
    else n_passed++;
    n_total++;
    if ({busy_o, done_o, timeout_o, tc_valid_o, pass_cnt_o, fail_cnt_o} !==
        {1'b0, 1'b1, tmo, 1'b0, CNT_W'(npass), CNT_W'(nfail)})
      $display("FAIL done_state got busy=%b done=%b tmo=%b valid=%b pass=%0d fail=%0d expected tmo=%b pass=%0d fail=%0d",
               busy_o, done_o, timeout_o, tc_valid_o, pass_cnt_o, fail_cnt_o, tmo, npass, nfail);
    else n_passed++;
    s_pass = npass;
    s_fail = nfail;
    s_tmo  = tmo;
  endtask

  task automatic test_reset();
    step();
    n_total++;
    if (all_outs !== '0) $display("FAIL reset_outputs got=%h expected 0", all_outs);
    else n_passed++;
    PRESETn = 1'b1;
    m_ptr   = 0;
    step();
    n_total++;
    if (all_outs !== '0) $display("FAIL idle_outputs got=%h expected 0", all_outs);
    else n_passed++;
  endtask

  task automatic test_round_robin();
    int p, f;
    bit t;
    run_session(1, p, f, t);
    n_total++;
    if (grants.size() != NUM_TESTS) $display("FAIL rr_grant_count got=%0d expected=%0d", grants.size(), NUM_TESTS);
    else n_passed++;
    for (int i = 0; i < grants.size(); i++) begin
      n_total++;
      if (grants[i] != i % NUM_REQ) $display("FAIL rr_order idx=%0d got=%0d expected=%0d", i, grants[i], i % NUM_REQ);
      else n_passed++;
    end
    n_total++;
    if ({pass_cnt_o, fail_cnt_o, timeout_o} !== {CNT_W'(4), CNT_W'(4), 1'b0})
      $display("FAIL rr_totals got pass=%0d fail=%0d tmo=%b expected 4 4 0", pass_cnt_o, fail_cnt_o, timeout_o);
    else n_passed++;
  endtask

  task automatic test_backpressure();
    int p, f;
    bit t;
    run_session(2, p, f, t);
    n_total++;
    if ({pass_cnt_o, fail_cnt_o} !== {CNT_W'(4), CNT_W'(4)})
      $display("FAIL bp_totals got pass=%0d fail=%0d expected 4 4", pass_cnt_o, fail_cnt_o);
    else n_passed++;
  endtask

  task automatic test_random();
    int p, f;
    bit t;
    for (int s = 0; s < 4; s++) run_session(0, p, f, t);
  endtask

  task automatic test_timeout();
    int p, f;
    bit t;
    run_session(3, p, f, t);
    n_total++;
    if ({done_o, timeout_o, pass_cnt_o, fail_cnt_o} !== {1'b1, 1'b1, CNT_W'(0), CNT_W'(0)})
      $display("FAIL timeout_flags got done=%b tmo=%b pass=%0d fail=%0d expected 1 1 0 0",
               done_o, timeout_o, pass_cnt_o, fail_cnt_o);
    else n_passed++;
  endtask

  task automatic test_reset_mid_emit();
    start_i     = 1'b1;
    tc_ready_i  = 1'b1;
    req_valid_i = '0;
    step();
    start_i = 1'b0;
    step();
    req_valid_i = '1;
    tc_ready_i  = 1'b0;
    step();
    n_total++;
    if (tc_valid_o !== 1'b1) $display("FAIL mid_emit_valid got=%b expected 1", tc_valid_o);
    else n_passed++;
    #2;
    PRESETn = 1'b0;
    #1;
    n_total++;
    if (all_outs !== '0) $display("FAIL async_reset_outputs got=%h expected 0", all_outs);
    else n_passed++;
    step();
    PRESETn = 1'b1;
    m_ptr   = 0;
    step();
    n_total++;
    if (all_outs !== '0) $display("FAIL post_reset_outputs got=%h expected 0", all_outs);
    else n_passed++;
  endtask

  task automatic test_restart_after_reset();
    int p, f;
    bit t;
    run_session(1, p, f, t);
    n_total++;
    if (grants.size() == 0 || grants[0] != 0)
      $display("FAIL restart_first_grant got=%0d expected=0", grants.size() ? grants[0] : -1);
    else n_passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid_emit();
    test_restart_after_reset();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
